micro_sequencer: RTL and testbench

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/micro_sequencer_pkg.sv | 63 ++++++
 rtl/micro_sequencer_if.sv | 24 ++
 rtl/micro_sequencer_ctrl_decode.sv | 40 ++++
 rtl/micro_sequencer.sv | 118 +++++++++++
 tb/tb_micro_sequencer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/micro_sequencer_pkg.sv
// Shared state codes, entry-code ranges and timeout default for the micro-sequencer
// and the instruction encoder that feeds it.
package micro_sequencer_pkg;

   localparam int MOC_TIMEOUT_DEFAULT = 15;
   localparam int CODE_W = 6;

   typedef logic [CODE_W-1:0] code_t;

   typedef enum logic [CODE_W-1:0] {
      S_RESET       = 6'd0,
      S_FETCH_MAR   = 6'd1,
      S_FETCH_PC    = 6'd2,
      S_FETCH_WAIT  = 6'd3,
      S_DECODE      = 6'd4,
      S_LINK        = 6'd42,
      S_BRANCH      = 6'd43,
      S_BRANCH_LINK = 6'd44,
      S_MEM_ADDR    = 6'd45,
      S_MEM_WAIT    = 6'd46,
      S_WRITEBACK   = 6'd47
   } state_e;

   localparam code_t DP_LO   = 6'd5;
   localparam code_t DP_HI   = 6'd7;
   localparam code_t LS_A_LO = 6'd12;
   localparam code_t LS_A_HI = 6'd26;
   localparam code_t LS_B_LO = 6'd35;
   localparam code_t LS_B_HI = 6'd41;

   typedef struct packed {
      logic mar_ld;
      logic ir_ld;
      logic pc_ld;
      logic rf_ld;
      logic mdr_ld;
      logic cc_ld;
      logic mfa;
      logic rw;
   } ctrl_t;

   function automatic logic is_dp(code_t c);
      return c inside {[DP_LO:DP_HI]};
   endfunction

   function automatic logic is_ls(code_t c);
      return c inside {[LS_A_LO:LS_A_HI], [LS_B_LO:LS_B_HI]};
   endfunction

   // Pre/post-indexed forms write the updated base back in the entry state.
   function automatic logic is_indexed(code_t c);
      return c inside {[6'd14:6'd18], [6'd22:6'd26], 6'd36, 6'd37, 6'd40, 6'd41};
   endfunction

   function automatic logic is_load(code_t c);
      return c inside {[6'd20:6'd26], [6'd39:6'd41]};
   endfunction

   function automatic logic is_entry(code_t c);
      return is_dp(c) || is_ls(c) || (c == S_BRANCH) || (c == S_BRANCH_LINK);
   endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Encoder/memory-facing signal bundle of the micro-sequencer.
interface micro_sequencer_if;
   import micro_sequencer_pkg::*;

   // mfa is the memory request, held while the sequencer sits in a wait state;
   // moc is the completion strobe, honoured only in FETCH_WAIT/MEM_WAIT at a rising edge.
   code_t enc_state;
   logic  cond_ok;
   logic  moc;
   code_t state;
   logic  mar_ld, ir_ld, pc_ld, rf_ld, mdr_ld, cc_ld;
   logic  mfa, rw, err;

   modport master (
      output enc_state, cond_ok, moc,
      input  state, mar_ld, ir_ld, pc_ld, rf_ld, mdr_ld, cc_ld, mfa, rw, err
   );

   modport slave (
      input  enc_state, cond_ok, moc,
      output state, mar_ld, ir_ld, pc_ld, rf_ld, mdr_ld, cc_ld, mfa, rw, err
   );

endinterface

// File: rtl/micro_sequencer_ctrl_decode.sv
// Moore decode of the current state code into register enables and memory controls.
module micro_sequencer_ctrl_decode
   import micro_sequencer_pkg::*;
(
   input  code_t state,
   input  logic  dir,
   output ctrl_t ctrl
);

   always_comb begin
      ctrl    = '0;
      ctrl.rw = 1'b1;
      case (state)
         S_FETCH_MAR:  ctrl.mar_ld = 1'b1;
         S_FETCH_PC:   ctrl.pc_ld  = 1'b1;
         S_FETCH_WAIT: begin
            ctrl.mfa   = 1'b1;
            ctrl.ir_ld = 1'b1;
         end
         S_MEM_ADDR:   ctrl.mar_ld = 1'b1;
         S_MEM_WAIT: begin
            ctrl.mfa    = 1'b1;
            ctrl.rw     = dir;
            ctrl.mdr_ld = dir;
         end
         S_WRITEBACK:  ctrl.rf_ld = 1'b1;
         S_LINK:       ctrl.rf_ld = 1'b1;
         S_BRANCH:     ctrl.pc_ld = 1'b1;
         default: begin
            if (is_dp(state)) begin
               ctrl.rf_ld = 1'b1;
               ctrl.cc_ld = 1'b1;
            end else if (is_ls(state) && is_indexed(state)) begin
               ctrl.rf_ld = 1'b1;
            end
         end
      endcase
   end

endmodule

// File: rtl/micro_sequencer.sv
// Instruction-level micro-sequencer: fetch, decode, dispatch to entry states, memory
// waits with timeout, and a sticky error flag for timeouts and illegal entry codes.
module micro_sequencer
   import micro_sequencer_pkg::*;
#(
   parameter int MOC_TIMEOUT = MOC_TIMEOUT_DEFAULT
) (
   input logic             clk,
   input logic             reset,
   micro_sequencer_if.slave bus
);

   localparam int CNT_W = $clog2(MOC_TIMEOUT + 1);

   code_t            state_q, state_d;
   logic             err_q, dir_q;
   logic [CNT_W-1:0] wait_cnt;
   logic             set_err, ld_dir, clr_cnt, inc_cnt, timeout;
   ctrl_t            ctrl;

   assign timeout = (wait_cnt == CNT_W'(MOC_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_RESET;
         err_q    <= 1'b0;
         dir_q    <= 1'b0;
         wait_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (set_err) err_q <= 1'b1;
         if (ld_dir)  dir_q <= is_load(state_q);
         if (clr_cnt)      wait_cnt <= '0;
         else if (inc_cnt) wait_cnt <= wait_cnt + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      set_err = 1'b0;
      ld_dir  = 1'b0;
      clr_cnt = 1'b0;
      inc_cnt = 1'b0;
      case (state_q)
         S_RESET:     state_d = S_FETCH_MAR;
         S_FETCH_MAR: state_d = S_FETCH_PC;
         S_FETCH_PC: begin
            state_d = S_FETCH_WAIT;
            clr_cnt = 1'b1;
         end
         S_FETCH_WAIT: begin
            if (bus.moc) begin
               state_d = S_DECODE;
            end else if (timeout) begin
               state_d = S_FETCH_MAR;
               set_err = 1'b1;
            end else begin
               inc_cnt = 1'b1;
            end
         end
         S_DECODE: begin
            if (!bus.cond_ok || bus.enc_state == S_RESET) begin
               state_d = S_FETCH_MAR;
            end else if (is_entry(bus.enc_state)) begin
               state_d = bus.enc_state;
            end else begin
               state_d = S_FETCH_MAR;
               set_err = 1'b1;
            end
         end
         S_MEM_ADDR: begin
            state_d = S_MEM_WAIT;
            clr_cnt = 1'b1;
         end
         S_MEM_WAIT: begin
            // Completion wins over a timeout landing in the same cycle.
            if (bus.moc) begin
               state_d = dir_q ? S_WRITEBACK : S_FETCH_MAR;
            end else if (timeout) begin
               state_d = S_FETCH_MAR;
               set_err = 1'b1;
            end else begin
               inc_cnt = 1'b1;
            end
         end
         S_WRITEBACK:   state_d = S_FETCH_MAR;
         S_LINK:        state_d = S_BRANCH;
         S_BRANCH:      state_d = S_FETCH_MAR;
         S_BRANCH_LINK: state_d = S_LINK;
         default: begin
            if (is_ls(state_q)) begin
               state_d = S_MEM_ADDR;
               ld_dir  = 1'b1;
            end else begin
               state_d = S_FETCH_MAR;
            end
         end
      endcase
   end

   micro_sequencer_ctrl_decode ctrl_decode (
      .state (state_q),
      .dir   (dir_q),
      .ctrl  (ctrl)
   );

   assign bus.state  = state_q;
   assign bus.err    = err_q;
   assign bus.mar_ld = ctrl.mar_ld;
   assign bus.ir_ld  = ctrl.ir_ld;
   assign bus.pc_ld  = ctrl.pc_ld;
   assign bus.rf_ld  = ctrl.rf_ld;
   assign bus.mdr_ld = ctrl.mdr_ld;
   assign bus.cc_ld  = ctrl.cc_ld;
   assign bus.mfa    = ctrl.mfa;
   assign bus.rw     = ctrl.rw;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: instruction-level trace model, per-cycle compare and
// literal trace checks for the main instruction classes, timeouts and reset.
module tb_micro_sequencer;
   import micro_sequencer_pkg::*;

   localparam int T = 15;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   micro_sequencer_if bus();

   micro_sequencer #(.MOC_TIMEOUT(T)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- model state ----------------
   typedef struct {
      bit rst;
      bit chk;
      int st;
      bit err;
      bit dir;
      bit moc;
      int enc;
      bit cond;
   } rec_t;

   rec_t       stim_q[$];
   logic [8:0] exp_q[$];       // {chk, state[5:0], err, dir}
   int         act_state[$];
   logic [7:0] act_ctrl[$];
   bit         act_err[$];
   int         lit[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   bit         m_err = 1'b0;
   bit         m_dir = 1'b0;

   function automatic int junk_code();
      return int'($urandom_range(0, 63));
   endfunction

   function automatic bit junk_bit();
      return bit'($urandom_range(0, 1));
   endfunction

   // Control outputs each state must show, straight from the state table.
   function automatic logic [7:0] exp_ctrl(int s, bit dir);
      bit mar, ir, pc, rf, mdr, cc, mfa, rw;
      mar = (s == 1) || (s == 45);
      ir  = (s == 3);
      pc  = (s == 2) || (s == 43);
      rf  = (s inside {5, 6, 7, 42, 47}) ||
            (s inside {[14:18], [22:26], 36, 37, 40, 41});
      mdr = (s == 46) && dir;
      cc  = s inside {[5:7]};
      mfa = (s == 3) || (s == 46);
      rw  = (s == 46) ? dir : 1'b1;
      return {mar, ir, pc, rf, mdr, cc, mfa, rw};
   endfunction

   task automatic check(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- trace builder ----------------
   task automatic push(bit rst_v, bit chk_v, int st, bit moc_v, int enc_v, bit cond_v);
      rec_t r;
      r.rst = rst_v; r.chk = chk_v; r.st = st; r.err = m_err; r.dir = m_dir;
      r.moc = moc_v; r.enc = enc_v; r.cond = cond_v;
      stim_q.push_back(r);
   endtask

   task automatic emit(int st);
      push(1'b0, 1'b1, st, junk_bit(), junk_code(), junk_bit());
   endtask

   // Wait of up to T cycles; w = cycle on which moc arrives (0 = never),
   // rst_at = cycle on which reset is raised (0 = never). res: 0 timeout, 1 moc, 2 reset.
   task automatic wait_phase(int st, int w, int rst_at, output int res);
      for (int k = 1; k <= T; k++) begin
         if (k == rst_at) begin
            push(1'b1, 1'b1, st, 1'b0, junk_code(), junk_bit());
            m_err = 1'b0;
            m_dir = 1'b0;
            emit(0);
            res = 2;
            return;
         end
         if (k == w) begin
            push(1'b0, 1'b1, st, 1'b1, junk_code(), junk_bit());
            res = 1;
            return;
         end
         push(1'b0, 1'b1, st, 1'b0, junk_code(), junk_bit());
      end
      m_err = 1'b1;
      res = 0;
   endtask

   task automatic instr(int enc, bit cond, int fw, int mw, int rst_at, output int start);
      int res;
      start = stim_q.size();
      emit(1);
      emit(2);
      wait_phase(3, fw, 0, res);
      if (res != 1) return;
      push(1'b0, 1'b1, 4, junk_bit(), enc, cond);
      if (!cond || enc == 0) return;
      if (enc inside {[5:7]}) begin
         emit(enc);
         return;
      end
      if (enc inside {[12:26], [35:41]}) begin
         emit(enc);
         m_dir = enc inside {[20:26], [39:41]};
         emit(45);
         wait_phase(46, mw, rst_at, res);
         if (res == 1 && m_dir) emit(47);
         return;
      end
      if (enc == 43) begin
         emit(43);
         return;
      end
      if (enc == 44) begin
         emit(44);
         emit(42);
         emit(43);
         return;
      end
      m_err = 1'b1;
   endtask

   task automatic check_lit(string name, int start);
      for (int i = 0; i < lit.size(); i++) begin
         if (start + i >= act_state.size()) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: trace too short at step %0d", name, i);
            return;
         end
         check(name, act_state[start + i], lit[i]);
      end
   endtask

   // ---------------- scoreboard compare ----------------
   logic [8:0] cmp_e;
   logic [7:0] cmp_ctrl;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         cmp_e    = exp_q.pop_front();
         cmp_ctrl = {bus.mar_ld, bus.ir_ld, bus.pc_ld, bus.rf_ld,
                     bus.mdr_ld, bus.cc_ld, bus.mfa, bus.rw};
         act_state.push_back(int'(bus.state));
         act_ctrl.push_back(cmp_ctrl);
         act_err.push_back(bus.err);
         if (cmp_e[8]) begin
            check("state", int'(bus.state), int'(cmp_e[7:2]));
            check("ctrl", int'(cmp_ctrl), int'(exp_ctrl(int'(cmp_e[7:2]), cmp_e[0])));
            check("err", int'(bus.err), int'(cmp_e[1]));
         end
      end
   end

   // ---------------- driver / directed program ----------------
   initial begin
      int sa, sb, sc, sd, se, sf, sg, sh, si, tmp;
      rec_t r;
      reset         = 1'b1;
      bus.enc_state = '0;
      bus.cond_ok   = 1'b0;
      bus.moc       = 1'b0;

      push(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
      push(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
      emit(0);
      instr(7,  1, 2, 0, 0, sa);
      instr(22, 1, 1, 1, 0, sb);
      instr(12, 1, 1, 1, 0, sc);
      instr(44, 1, 1, 0, 0, sd);
      instr(44, 0, 1, 0, 0, se);
      instr(5,  1, 3, 0, 0, tmp);
      instr(41, 1, 2, 2, 0, tmp);
      instr(36, 1, 1, 3, 0, tmp);
      instr(43, 1, 1, 0, 0, tmp);
      instr(0,  1, 1, 0, 0, tmp);
      instr(26, 1, 1, 4, 0, tmp);
      instr(20, 1, 1, 15, 0, sf);
      instr(13, 1, 1, 0, 0, sg);
      instr(21, 1, 1, 0, 5, sh);
      instr(63, 1, 1, 0, 0, si);
      instr(3,  1, 1, 0, 0, tmp);
      instr(7,  1, 0, 0, 0, tmp);
      instr(6,  1, 1, 0, 0, tmp);
      instr(7,  1, 1, 0, 0, tmp);

      while (stim_q.size() > 0) begin
         @(posedge clk);
         #1;
         r             = stim_q.pop_front();
         reset         = r.rst;
         bus.moc       = r.moc;
         bus.enc_state = 6'(r.enc);
         bus.cond_ok   = r.cond;
         exp_q.push_back({r.chk, 6'(r.st), r.err, r.dir});
      end
      repeat (2) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
      end

      // Hand-computed traces pinning the model.
      check("rst_state", act_state[2], 0);
      check("rst_ctrl", int'(act_ctrl[2]), 8'h01);
      check("rst_err", int'(act_err[2]), 0);
      lit = '{1, 2, 3, 3, 4, 7, 1};
      check_lit("dp7_trace", sa);
      check("dp7_rf_cc", int'({act_ctrl[sa + 5][4], act_ctrl[sa + 5][2]}), 3);
      lit = '{1, 2, 3, 4, 22, 45, 46, 47, 1};
      check_lit("ld22_trace", sb);
      check("ld22_rf", int'(act_ctrl[sb + 4][4]), 1);
      check("ld22_memwait", int'({act_ctrl[sb + 6][1], act_ctrl[sb + 6][0], act_ctrl[sb + 6][3]}), 7);
      lit = '{1, 2, 3, 4, 12, 45, 46, 1};
      check_lit("st12_trace", sc);
      check("st12_rw", int'(act_ctrl[sc + 6][0]), 0);
      lit = '{1, 2, 3, 4, 44, 42, 43, 1};
      check_lit("bl44_trace", sd);
      check("bl44_link_rf", int'(act_ctrl[sd + 5][4]), 1);
      check("bl44_pc", int'(act_ctrl[sd + 6][5]), 1);
      lit = '{1, 2, 3, 4, 1};
      check_lit("cond0_trace", se);
      lit = '{1, 2, 3, 4, 20, 45};
      repeat (15) lit.push_back(46);
      lit.push_back(47);
      lit.push_back(1);
      check_lit("moc15_trace", sf);
      check("moc15_err", int'(act_err[sf + 21]), 0);
      lit = '{1, 2, 3, 4, 13, 45};
      repeat (15) lit.push_back(46);
      lit.push_back(1);
      check_lit("timeout_trace", sg);
      check("timeout_err_before", int'(act_err[sg + 20]), 0);
      check("timeout_err_after", int'(act_err[sg + 21]), 1);
      lit = '{1, 2, 3, 4, 21, 45, 46, 46, 46, 46, 46, 0, 1};
      check_lit("midreset_trace", sh);
      check("midreset_err", int'(act_err[sh + 11]), 0);
      lit = '{1, 2, 3, 4, 1};
      check_lit("illegal_trace", si);
      check("illegal_err_before", int'(act_err[si + 3]), 0);
      check("illegal_err_after", int'(act_err[si + 4]), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
